// File: rtl/store_data_queue.sv
// store_data_queue: posted write-back buffer between the D-cache and the system bus.
// Dirty-line evictions are queued in a DEPTH-entry FIFO and drained in order: an arbiter
// request, one address beat, then LINE_BEATS data beats. A lookup port reports whether a
// load's line is still pending (queued or in flight).
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_enq_valid/o_enq_ready, i_enq_addr, i_enq_data   line enqueue (beat0 = low bits)
//   i_lookup_addr/o_lookup_hit                        combinational pending-line check
//   o_count               valid entries including the in-flight head
//   o_done                1-cycle pulse when a line finishes
//   o_abtr_reqcyc/i_abtr_grant                        bus arbiter handshake
//   o_bus_busy            bus owned from the address beat through the end cycle
//   o_main_bus_reqcyc/i_main_bus_reqack, o_main_bus_req, o_main_bus_reqtag  request channel
//   o_main_bus_respack    tied 0, writes get no response
//
// Build option: define STORE_DATA_QUEUE_COALESCE_EN to merge an enqueue into a queued
// (not in-flight) entry of the same line instead of allocating a new slot.

`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module store_data_queue #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned LINE_BEATS     = 8,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned BUS_TAG_WIDTH  = 13
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_enq_valid,
    output logic                                 o_enq_ready,
    input  logic [BUS_DATA_WIDTH-1:0]            i_enq_addr,
    input  logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] i_enq_data,
    input  logic [BUS_DATA_WIDTH-1:0]            i_lookup_addr,
    output logic                                 o_lookup_hit,
    output logic [$clog2(DEPTH):0]               o_count,
    output logic                                 o_done,
    output logic                                 o_abtr_reqcyc,
    input  logic                                 i_abtr_grant,
    output logic                                 o_bus_busy,
    output logic                                 o_main_bus_reqcyc,
    input  logic                                 i_main_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0]            o_main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]             o_main_bus_reqtag,
    output logic                                 o_main_bus_respack
);

    localparam int unsigned LINE_W = BUS_DATA_WIDTH * LINE_BEATS;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = $clog2(LINE_BEATS);

    // Byte-offset bits within one line; cleared to form the line address.
    localparam logic [BUS_DATA_WIDTH-1:0] LINE_OFS_MASK =
        BUS_DATA_WIDTH'(BUS_DATA_WIDTH / 8 * LINE_BEATS - 1);

    localparam logic [BUS_TAG_WIDTH-1:0] BURST_TAG =
        (BUS_TAG_WIDTH'(`SYSBUS_WRITE) << 12) | (BUS_TAG_WIDTH'(`SYSBUS_MEMORY) << 8);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_END  = 3'd4;

    logic [2:0]                r_state;
    logic [BEAT_W-1:0]         r_beat;
    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [CNT_W-1:0]          r_count;
    logic [BUS_DATA_WIDTH-1:0] r_line_addr [DEPTH];
    logic [LINE_W-1:0]         r_line_data [DEPTH];

    logic [2:0]                w_state_nxt;
    logic [BEAT_W-1:0]         w_beat_nxt;
    logic [BUS_DATA_WIDTH-1:0] w_enq_line;
    logic [BUS_DATA_WIDTH-1:0] w_lookup_line;
    logic [DEPTH-1:0]          w_valid;
    logic                      w_in_flight;
    logic                      w_coal_hit;
    logic [PTR_W-1:0]          w_coal_idx;
    logic                      w_enq_fire;
    logic                      w_alloc;
    logic                      w_pop;
    logic [PTR_W-1:0]          w_wr_idx;
    logic [BUS_DATA_WIDTH-1:0] w_head_beat;

    assign w_enq_line    = i_enq_addr & ~LINE_OFS_MASK;
    assign w_lookup_line = i_lookup_addr & ~LINE_OFS_MASK;
    // From ARB onward the head belongs to the bus and must not be modified.
    assign w_in_flight   = (r_state != S_IDLE);

    // Slot i is valid when its distance from the head (mod DEPTH) is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = {1'b0, PTR_W'(i) - r_head} < r_count;
        end
    end

    always_comb begin
        o_lookup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (r_line_addr[i] == w_lookup_line)) begin
                o_lookup_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = '0;
`ifdef STORE_DATA_QUEUE_COALESCE_EN
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (r_line_addr[i] == w_enq_line) &&
                !(w_in_flight && (PTR_W'(i) == r_head))) begin
                w_coal_hit = 1'b1;
                w_coal_idx = PTR_W'(i);
            end
        end
`endif
    end

    // A coalescing write needs no free slot, so it is accepted even when full.
    assign o_enq_ready = (r_count < CNT_W'(DEPTH)) || w_coal_hit;
    assign w_enq_fire  = i_enq_valid && o_enq_ready;
    assign w_alloc     = w_enq_fire && !w_coal_hit;
    assign w_pop       = (r_state == S_END);
    assign w_wr_idx    = w_coal_hit ? w_coal_idx : r_tail;
    assign w_head_beat = r_line_data[r_head][r_beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            S_IDLE: if (r_count != '0) w_state_nxt = S_ARB;
            S_ARB:  if (i_abtr_grant) w_state_nxt = S_ADDR;
            S_ADDR: begin
                if (i_main_bus_reqack) begin
                    w_state_nxt = S_DATA;
                    w_beat_nxt  = '0;
                end
            end
            S_DATA: begin
                if (i_main_bus_reqack) begin
                    if (r_beat == BEAT_W'(LINE_BEATS - 1)) begin
                        w_state_nxt = S_END;
                    end else begin
                        w_beat_nxt = r_beat + BEAT_W'(1);
                    end
                end
            end
            S_END:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_abtr_reqcyc     = 1'b0;
        o_bus_busy        = 1'b0;
        o_main_bus_reqcyc = 1'b0;
        o_main_bus_req    = '0;
        o_main_bus_reqtag = '0;
        o_done            = 1'b0;
        case (r_state)
            S_ARB: o_abtr_reqcyc = 1'b1;
            S_ADDR: begin
                o_bus_busy        = 1'b1;
                o_main_bus_reqcyc = 1'b1;
                o_main_bus_req    = r_line_addr[r_head];
                o_main_bus_reqtag = BURST_TAG;
            end
            S_DATA: begin
                o_bus_busy        = 1'b1;
                o_main_bus_reqcyc = 1'b1;
                o_main_bus_req    = w_head_beat;
                o_main_bus_reqtag = BURST_TAG;
            end
            S_END: begin
                o_bus_busy = 1'b1;
                o_done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_count            = r_count;
    assign o_main_bus_respack = 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_alloc) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)   r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
        end
    end

    // Payload storage needs no reset; validity is tracked by head/count.
    always_ff @(posedge i_clk) begin
        if (w_enq_fire) begin
            r_line_addr[w_wr_idx] <= w_enq_line;
            r_line_data[w_wr_idx] <= i_enq_data;
        end
    end

endmodule
